// File: rtl/execute_flag_condition_unit.sv
// Execute-stage condition unit: holds a conditional request until every older
// flag writer has committed, then evaluates its condition code against iFLAG.
module execute_flag_condition_unit #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             iCLOCK,
    input  logic             iRESET_SYNC,
    input  logic             iFLUSH,
    input  logic [4:0]       iFLAG,
    input  logic             iFLAG_WR_ISSUE,
    input  logic             iFLAG_WR_DONE,
    input  logic             iREQ_VALID,
    input  logic [3:0]       iREQ_CC,
    input  logic [TAG_W-1:0] iREQ_TAG,
    output logic             oREQ_BUSY,
    output logic             oRES_VALID,
    output logic             oRES_TAKEN,
    output logic [TAG_W-1:0] oRES_TAG,
    input  logic             iRES_BUSY,
    output logic [CNT_W-1:0] oPENDING,
    output logic             oERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] pendingNext;
    logic             errSet;
    logic             err;
    logic [3:0]       ccReg;
    logic [TAG_W-1:0] tagReg;
    logic             resValid;
    logic             resTaken;
    logic [TAG_W-1:0] resTag;

    // Flag layout is {P,O,C,S,Z}; signed compares use S against O.
    function automatic logic evalCondition(input logic [3:0] cc, input logic [4:0] flag);
        logic z, s, c, o, p;
        logic result;
        z = flag[0];
        s = flag[1];
        c = flag[2];
        o = flag[3];
        p = flag[4];
        case (cc)
            4'd0:    result = 1'b1;
            4'd1:    result = z;
            4'd2:    result = !z;
            4'd3:    result = s;
            4'd4:    result = !s;
            4'd5:    result = c;
            4'd6:    result = !c;
            4'd7:    result = o;
            4'd8:    result = !o;
            4'd9:    result = c & !z;
            4'd10:   result = !c | z;
            4'd11:   result = (s == o);
            4'd12:   result = (s != o);
            4'd13:   result = !z & (s == o);
            4'd14:   result = z | (s != o);
            default: result = p;
        endcase
        return result;
    endfunction

    always_comb begin
        pendingNext = pending;
        errSet      = 1'b0;
        if (iFLAG_WR_ISSUE && !iFLAG_WR_DONE) begin
            if (pending == PEND_MAX) begin
                errSet = 1'b1;
            end else begin
                pendingNext = pending + PEND_ONE;
            end
        end else if (iFLAG_WR_DONE && !iFLAG_WR_ISSUE) begin
            if (pending == '0) begin
                errSet = 1'b1;
            end else begin
                pendingNext = pending - PEND_ONE;
            end
        end
    end

    // Flush drops in-flight writer tracking but the error flag survives until reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            pending <= '0;
            err     <= 1'b0;
        end else if (iFLUSH) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
            if (errSet) begin
                err <= 1'b1;
            end
        end
    end

    // A writer issued in the accept cycle is already in the registered count seen by WAIT.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state    <= IDLE;
            ccReg    <= '0;
            tagReg   <= '0;
            resValid <= 1'b0;
            resTaken <= 1'b0;
            resTag   <= '0;
        end else if (iFLUSH) begin
            state    <= IDLE;
            resValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREQ_VALID) begin
                        ccReg  <= iREQ_CC;
                        tagReg <= iREQ_TAG;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (pending == '0) begin
                        resTaken <= evalCondition(ccReg, iFLAG);
                        resTag   <= tagReg;
                        resValid <= 1'b1;
                        state    <= RESULT;
                    end
                end
                RESULT: begin
                    if (!iRES_BUSY) begin
                        resValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    resValid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign oREQ_BUSY  = (state != IDLE) | iFLUSH;
    assign oRES_VALID = resValid;
    assign oRES_TAKEN = resTaken;
    assign oRES_TAG   = resTag;
    assign oPENDING   = pending;
    assign oERR       = err;

endmodule

// File: tb/tb_execute_flag_condition_unit.sv
// Directed bench for execute_flag_condition_unit; expected results are queued
// when a request is driven and popped when the unit presents a result.
module tb_execute_flag_condition_unit;

    localparam int TAG_W = 4;
    localparam int CNT_W = 3;

    typedef struct {
        logic             taken;
        logic [TAG_W-1:0] tag;
    } expect_t;

    logic             iCLOCK = 1'b0;
    logic             iRESET_SYNC;
    logic             iFLUSH;
    logic [4:0]       iFLAG;
    logic             iFLAG_WR_ISSUE;
    logic             iFLAG_WR_DONE;
    logic             iREQ_VALID;
    logic [3:0]       iREQ_CC;
    logic [TAG_W-1:0] iREQ_TAG;
    logic             oREQ_BUSY;
    logic             oRES_VALID;
    logic             oRES_TAKEN;
    logic [TAG_W-1:0] oRES_TAG;
    logic             iRES_BUSY;
    logic [CNT_W-1:0] oPENDING;
    logic             oERR;

    expect_t scoreboard[$];
    int checkCount = 0;
    int errorCount = 0;

    execute_flag_condition_unit #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iFLUSH(iFLUSH), .iFLAG(iFLAG),
        .iFLAG_WR_ISSUE(iFLAG_WR_ISSUE), .iFLAG_WR_DONE(iFLAG_WR_DONE),
        .iREQ_VALID(iREQ_VALID), .iREQ_CC(iREQ_CC), .iREQ_TAG(iREQ_TAG),
        .oREQ_BUSY(oREQ_BUSY), .oRES_VALID(oRES_VALID), .oRES_TAKEN(oRES_TAKEN),
        .oRES_TAG(oRES_TAG), .iRES_BUSY(iRES_BUSY), .oPENDING(oPENDING), .oERR(oERR)
    );

    always #5 iCLOCK = ~iCLOCK;

    // Reference condition table, flags named individually from {P,O,C,S,Z}.
    function automatic logic modelTaken(input logic [3:0] cc, input logic [4:0] f);
        logic zf, sf, cf, vf, pf;
        {pf, vf, cf, sf, zf} = f;
        case (cc)
            4'd0:    return 1'b1;
            4'd1:    return zf;
            4'd2:    return ~zf;
            4'd3:    return sf;
            4'd4:    return ~sf;
            4'd5:    return cf;
            4'd6:    return ~cf;
            4'd7:    return vf;
            4'd8:    return ~vf;
            4'd9:    return cf && !zf;
            4'd10:   return !cf || zf;
            4'd11:   return sf ~^ vf;
            4'd12:   return sf ^ vf;
            4'd13:   return !zf && (sf ~^ vf);
            4'd14:   return zf || (sf ^ vf);
            default: return pf;
        endcase
    endfunction

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one request for one cycle; pushes the expected result unless it will be flushed.
    task automatic applyStimulus(input logic [3:0] cc, input logic [TAG_W-1:0] tag, input bit expectResult);
        expect_t e;
        iREQ_VALID = 1'b1;
        iREQ_CC    = cc;
        iREQ_TAG   = tag;
        if (expectResult) begin
            e.taken = modelTaken(cc, iFLAG);
            e.tag   = tag;
            scoreboard.push_back(e);
        end
        step();
        iREQ_VALID = 1'b0;
    endtask

    task automatic waitResult(input int maxCycles, input string tag, output int cycles);
        expect_t e;
        cycles = 0;
        while (!oRES_VALID && cycles < maxCycles) begin
            step();
            cycles++;
        end
        if (!oRES_VALID) begin
            checkOutput({tag, "_timeout"}, 32'(oRES_VALID), 32'd1);
        end else if (scoreboard.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'(scoreboard.size()), 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({tag, "_taken"}, 32'(oRES_TAKEN), 32'(e.taken));
            checkOutput({tag, "_tag"}, 32'(oRES_TAG), 32'(e.tag));
        end
    endtask

    task automatic pulseReset();
        iRESET_SYNC = 1'b1;
        step();
        step();
        iRESET_SYNC = 1'b0;
    endtask

    initial begin
        int lat;
        iRESET_SYNC = 1'b0; iFLUSH = 1'b0; iFLAG = '0;
        iFLAG_WR_ISSUE = 1'b0; iFLAG_WR_DONE = 1'b0;
        iREQ_VALID = 1'b0; iREQ_CC = '0; iREQ_TAG = '0; iRES_BUSY = 1'b0;
        pulseReset();

        // T1: reset while waiting on a pending writer
        iFLAG_WR_ISSUE = 1'b1; step(); iFLAG_WR_ISSUE = 1'b0;
        applyStimulus(4'd0, 4'd1, 1'b0);
        checkOutput("t1_pre_busy", 32'(oREQ_BUSY), 32'd1);
        pulseReset();
        checkOutput("t1_valid", 32'(oRES_VALID), 32'd0);
        checkOutput("t1_pending", 32'(oPENDING), 32'd0);
        checkOutput("t1_err", 32'(oERR), 32'd0);
        checkOutput("t1_busy", 32'(oREQ_BUSY), 32'd0);

        // T2: no hazard, result two cycles after request
        iFLAG = 5'b00001;
        applyStimulus(4'd1, 4'd3, 1'b1);
        checkOutput("t2_busy_wait", 32'(oREQ_BUSY), 32'd1);
        checkOutput("t2_valid_early", 32'(oRES_VALID), 32'd0);
        waitResult(4, "t2", lat);
        checkOutput("t2_latency", 32'(lat), 32'd1);
        step();
        checkOutput("t2_valid_drop", 32'(oRES_VALID), 32'd0);
        checkOutput("t2_idle", 32'(oREQ_BUSY), 32'd0);

        // T3: two outstanding writers, second issued in the accept cycle
        iFLAG = 5'b00010;
        iFLAG_WR_ISSUE = 1'b1; step();
        applyStimulus(4'd12, 4'd5, 1'b1);
        iFLAG_WR_ISSUE = 1'b0;
        checkOutput("t3_pending2", 32'(oPENDING), 32'd2);
        step(); step();
        iFLAG_WR_DONE = 1'b1; step(); iFLAG_WR_DONE = 1'b0;
        checkOutput("t3_pending1", 32'(oPENDING), 32'd1);
        checkOutput("t3_hold1", 32'(oRES_VALID), 32'd0);
        step(); step();
        iFLAG_WR_DONE = 1'b1; step(); iFLAG_WR_DONE = 1'b0;
        checkOutput("t3_pending0", 32'(oPENDING), 32'd0);
        checkOutput("t3_hold2", 32'(oRES_VALID), 32'd0);
        waitResult(4, "t3", lat);
        checkOutput("t3_latency", 32'(lat), 32'd1);
        step();

        // T4: downstream backpressure holds the result
        iFLAG = 5'b01100;
        iRES_BUSY = 1'b1;
        applyStimulus(4'd9, 4'd9, 1'b1);
        waitResult(4, "t4", lat);
        iREQ_VALID = 1'b1; iREQ_CC = 4'd0; iREQ_TAG = 4'd2;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_valid", 32'(oRES_VALID), 32'd1);
            checkOutput("t4_taken", 32'(oRES_TAKEN), 32'd1);
            checkOutput("t4_tag", 32'(oRES_TAG), 32'd9);
            checkOutput("t4_busy", 32'(oREQ_BUSY), 32'd1);
            step();
        end
        iREQ_VALID = 1'b0;
        iRES_BUSY = 1'b0;
        step();
        checkOutput("t4_release_valid", 32'(oRES_VALID), 32'd0);
        checkOutput("t4_release_idle", 32'(oREQ_BUSY), 32'd0);

        // T5: flush while waiting on two writers
        iFLAG_WR_ISSUE = 1'b1; step(); step(); iFLAG_WR_ISSUE = 1'b0;
        applyStimulus(4'd0, 4'd7, 1'b0);
        checkOutput("t5_pending2", 32'(oPENDING), 32'd2);
        iFLUSH = 1'b1;
        #1;
        checkOutput("t5_flush_busy", 32'(oREQ_BUSY), 32'd1);
        step();
        iFLUSH = 1'b0;
        #1;
        checkOutput("t5_pending0", 32'(oPENDING), 32'd0);
        checkOutput("t5_no_result", 32'(oRES_VALID), 32'd0);
        checkOutput("t5_idle", 32'(oREQ_BUSY), 32'd0);
        iFLAG = 5'b00000;
        applyStimulus(4'd2, 4'd8, 1'b1);
        checkOutput("t5_accepted", 32'(oREQ_BUSY), 32'd1);
        waitResult(4, "t5", lat);
        step();

        // T6: counter edges and sticky error
        iFLAG_WR_ISSUE = 1'b1; step();
        iFLAG_WR_DONE = 1'b1; step();
        iFLAG_WR_ISSUE = 1'b0;
        checkOutput("t6_both", 32'(oPENDING), 32'd1);
        step();
        iFLAG_WR_DONE = 1'b0;
        checkOutput("t6_dec", 32'(oPENDING), 32'd0);
        checkOutput("t6_err_clean", 32'(oERR), 32'd0);
        iFLAG_WR_DONE = 1'b1; step(); iFLAG_WR_DONE = 1'b0;
        checkOutput("t6_under_pending", 32'(oPENDING), 32'd0);
        checkOutput("t6_under_err", 32'(oERR), 32'd1);
        pulseReset();
        iFLAG_WR_ISSUE = 1'b1;
        for (int i = 0; i < 7; i++) step();
        checkOutput("t6_seven_err", 32'(oERR), 32'd0);
        step();
        iFLAG_WR_ISSUE = 1'b0;
        checkOutput("t6_sat_pending", 32'(oPENDING), 32'd7);
        checkOutput("t6_over_err", 32'(oERR), 32'd1);
        iFLUSH = 1'b1; step(); iFLUSH = 1'b0;
        checkOutput("t6_flush_pending", 32'(oPENDING), 32'd0);
        checkOutput("t6_flush_err", 32'(oERR), 32'd1);
        pulseReset();
        checkOutput("t6_reset_err", 32'(oERR), 32'd0);

        // Full condition sweep
        for (int cc = 0; cc < 16; cc++) begin
            for (int f = 0; f < 32; f++) begin
                iFLAG = 5'(f);
                applyStimulus(4'(cc), 4'(cc), 1'b1);
                waitResult(4, $sformatf("sweep_cc%0d_f%0d", cc, f), lat);
                step();
            end
        end
        checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
